// File: rtl/axi_read_scheduler.sv
// axi_read_scheduler: round-robin sharing of one AXI read channel (AR + R) among MASTERS requesters.
// Latency: request in cycle N -> ARVALID in N+1; R beats pass through combinationally; one burst in flight.
// Backpressure: m_arready mirrors ARREADY for the granted master, RREADY mirrors m_rready[grant].
// Optional: define ARB_WATCHDOG_EN to abandon bursts that stall for TIMEOUT cycles.
module axi_read_scheduler #(
  parameter int MASTERS    = 3,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  // requester side
  input  logic [MASTERS-1:0]              m_arvalid,
  input  logic [MASTERS*ADDR_WIDTH-1:0]   m_araddr,
  input  logic [MASTERS*4-1:0]            m_arlen,
  output logic [MASTERS-1:0]              m_arready,
  output logic [MASTERS-1:0]              m_rvalid,
  output logic                            m_rlast,
  output logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic [MASTERS-1:0]              m_rready,
  // AXI read port
  output logic                            ARVALID,
  output logic [3:0]                      ARID,
  output logic [3:0]                      ARLEN,
  output logic [ADDR_WIDTH-1:0]           ARADDR,
  input  logic                            ARREADY,
  input  logic                            RVALID,
  input  logic                            RLAST,
  input  logic [3:0]                      RID,
  input  logic [DATA_WIDTH-1:0]           RDATA,
  output logic                            RREADY,
  // status
  output logic                            busy,
  output logic                            err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [1:0]              r_rr_ptr;
  logic [1:0]              r_grant;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [3:0]              r_arlen;
  logic [3:0]              r_beat_cnt;
  logic                    r_err;

  logic                    w_live;
  logic                    w_any;
  logic                    w_found;
  logic [1:0]              w_win;
  logic [1:0]              w_grant_inc;
  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_proto_err;
  logic                    w_wdog_fire;

  // Outputs are forced low during the reset cycle itself, not only after it.
  assign w_live = ~rst;
  assign w_any  = |m_arvalid;

  // Round-robin search: first requesting index at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int k = 0; k < MASTERS; k++) begin
      if (!w_found && m_arvalid[(int'(r_rr_ptr) + k) % MASTERS]) begin
        w_found = 1'b1;
        w_win   = 2'((int'(r_rr_ptr) + k) % MASTERS);
      end
    end
  end

  assign w_grant_inc = (r_grant == 2'(MASTERS - 1)) ? 2'd0 : r_grant + 2'd1;

  // A beat is consumed only in DATA with the granted master ready.
  assign w_beat      = RREADY & RVALID;
  assign w_last_beat = w_beat & RLAST;

  // Protocol checks: stray beats outside DATA, wrong RID, RLAST vs beat count mismatch.
  assign w_proto_err = ((r_state != ST_DATA) && RVALID) ||
                       (w_beat && ((RID != {2'b00, r_grant}) ||
                                   ( RLAST && (r_beat_cnt != r_arlen)) ||
                                   (!RLAST && (r_beat_cnt == r_arlen))));

`ifdef ARB_WATCHDOG_EN
  logic [15:0] r_wdog;

  // Idle counter: restarts on every beat and on entry to ADDR/DATA, counts stalled cycles otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if ((r_state == ST_IDLE) || w_beat || ((r_state == ST_ADDR) && ARREADY)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  // Fires on the TIMEOUT-th consecutive stalled cycle; a beat in that cycle counts as progress.
  assign w_wdog_fire = (r_state != ST_IDLE) && !w_beat && (r_wdog == 16'(TIMEOUT - 1));
`else
  // Watchdog compiled out: a burst is never abandoned (TIMEOUT is never negative).
  assign w_wdog_fire = (TIMEOUT < 0);
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: grant -> address handshake -> beats until RLAST (or watchdog abort).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)       w_state_nxt = ST_ADDR;
      ST_ADDR: if (ARREADY)     w_state_nxt = ST_DATA;
      ST_DATA: if (w_last_beat) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
    if (w_wdog_fire) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Grant/request latch, beat counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_beat_cnt <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_grant  <= w_win;
        r_araddr <= m_araddr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
        r_arlen  <= m_arlen[int'(w_win)*4 +: 4];
      end
      if ((r_state == ST_ADDR) && ARREADY) begin
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
      end
      if (w_last_beat || w_wdog_fire) begin
        r_rr_ptr <= w_grant_inc;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_proto_err || w_wdog_fire) begin
      r_err <= 1'b1;
    end
  end

  // AXI address channel driven straight from the latched request.
  assign ARVALID = w_live && (r_state == ST_ADDR);
  assign ARID    = {2'b00, r_grant};
  assign ARLEN   = r_arlen;
  assign ARADDR  = r_araddr;
  assign RREADY  = w_live && (r_state == ST_DATA) && m_rready[r_grant];

  // Per-master handshake steering: one-hot to the granted master only.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    for (int i = 0; i < MASTERS; i++) begin
      m_arready[i] = w_live && (r_state == ST_ADDR) && ARREADY && (r_grant == 2'(i));
      m_rvalid[i]  = w_live && (r_state == ST_DATA) && RVALID  && (r_grant == 2'(i));
    end
  end

  assign m_rdata = RDATA;
  assign m_rlast = RLAST;
  assign busy    = w_live && (r_state != ST_IDLE);
  assign err     = r_err;

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Directed bench for axi_read_scheduler with hand-computed expectations.
// Inputs change 1 time unit after posedge; outputs are sampled 2 units after posedge.
// Watchdog scenario is compiled only when ARB_WATCHDOG_EN is defined (TIMEOUT=16).
module tb_axi_read_scheduler;
  localparam int M  = 3;
  localparam int AW = 26;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [M-1:0]    m_arvalid;
  logic [M*AW-1:0] m_araddr;
  logic [M*4-1:0]  m_arlen;
  logic [M-1:0]    m_arready;
  logic [M-1:0]    m_rvalid;
  logic            m_rlast;
  logic [DW-1:0]   m_rdata;
  logic [M-1:0]    m_rready;
  logic            ARVALID;
  logic [3:0]      ARID;
  logic [3:0]      ARLEN;
  logic [AW-1:0]   ARADDR;
  logic            ARREADY;
  logic            RVALID;
  logic            RLAST;
  logic [3:0]      RID;
  logic [DW-1:0]   RDATA;
  logic            RREADY;
  logic            busy;
  logic            err;

  int n_chk = 0;
  int n_err = 0;

  axi_read_scheduler #(
    .MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .m_rdata(m_rdata), .m_rready(m_rready),
    .ARVALID(ARVALID), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .ARREADY(ARREADY), .RVALID(RVALID), .RLAST(RLAST), .RID(RID),
    .RDATA(RDATA), .RREADY(RREADY), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    m_arvalid = '0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    RID       = '0;
    RDATA     = '0;
    m_rready  = '1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle with the request already driven; returns in the IDLE cycle after the burst.
  task automatic do_burst(input int id, input int len);
    logic [AW-1:0] exp_addr;
    exp_addr = m_araddr[id*AW +: AW];
    ARREADY = 1'b1;
    step();
    #1;
    check("ar_valid", ARVALID, 1);
    check("ar_id", ARID, id);
    check("ar_len", ARLEN, len);
    check("ar_addr", ARADDR, exp_addr);
    check("ar_ready_pulse", m_arready, 64'(1 << id));
    step();
    ARREADY = 1'b0;
    for (int b = 0; b <= len; b++) begin
      RVALID = 1'b1;
      RID    = 4'(id);
      RDATA  = 32'hD000_0000 | 32'(id << 4) | 32'(b);
      RLAST  = (b == len);
      #1;
      check("r_steer", m_rvalid, 64'(1 << id));
      check("r_data", m_rdata, 32'hD000_0000 | 32'(id << 4) | 32'(b));
      check("r_last", m_rlast, (b == len));
      check("r_ready", RREADY, 1);
      check("arready_idle_data", m_arready, 0);
      step();
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    #1;
    check("busy_after_burst", busy, 0);
  endtask

  initial begin
    m_araddr = '0;
    m_arlen  = '0;
    do_reset();
    #1;
    // reset state
    check("rst_busy", busy, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_arready", m_arready, 0);
    check("rst_err", err, 0);

    // single request, len 3
    m_araddr[0 +: AW] = 26'h0001000;
    m_arlen[0 +: 4]   = 4'd3;
    m_arvalid         = 3'b001;
    #1;
    check("req_cycle_arvalid", ARVALID, 0);
    do_burst(0, 3);
    m_arvalid = 3'b000;
    check("single_err", err, 0);

    // all three request continuously, len 0
    do_reset();
    m_araddr  = {26'h0300040, 26'h0200020, 26'h0100010};
    m_arlen   = '0;
    m_arvalid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      do_burst(n % 3, 0);
    end

    // wrap: last grant 2, requests from 0 and 2 only
    m_arvalid = 3'b101;
    do_burst(0, 0);
    do_burst(2, 0);
    do_burst(0, 0);
    m_arvalid = 3'b000;

    // ARREADY stalled 5 cycles, request dropped after one cycle
    m_araddr[1*AW +: AW] = 26'h2A5A5A4;
    m_arlen[4 +: 4]      = 4'd1;
    m_arvalid            = 3'b010;
    step();
    #1;
    check("stall_arvalid", ARVALID, 1);
    check("stall_addr_1", ARADDR, 26'h2A5A5A4);
    m_arvalid            = 3'b000;
    m_araddr[1*AW +: AW] = 26'h0000000;
    m_arlen[4 +: 4]      = 4'hF;
    for (int c = 2; c <= 6; c++) begin
      step();
      ARREADY = (c == 6);
      #1;
      check("stall_addr", ARADDR, 26'h2A5A5A4);
      check("stall_len", ARLEN, 4'd1);
      check("stall_arready", m_arready, (c == 6) ? 3'b010 : 3'b000);
    end
    step();
    ARREADY = 1'b0;
    for (int b = 0; b < 2; b++) begin
      RVALID = 1'b1;
      RID    = 4'd1;
      RLAST  = (b == 1);
      #1;
      check("stall_steer", m_rvalid, 3'b010);
      step();
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    #1;
    check("stall_busy", busy, 0);
    check("stall_err", err, 0);

    // early RLAST: beat index 1 of a len-3 burst from master 2
    m_arlen[8 +: 4] = 4'd3;
    m_arvalid       = 3'b100;
    ARREADY         = 1'b1;
    step();
    #1;
    check("early_arid", ARID, 2);
    m_arvalid = 3'b000;
    step();
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    RID     = 4'd2;
    RLAST   = 1'b0;
    step();
    RLAST = 1'b1;
    #1;
    check("early_err_pre", err, 0);
    step();
    RVALID = 1'b0;
    RLAST  = 1'b0;
    #1;
    check("early_err", err, 1);
    check("early_idle", busy, 0);

    // wrong RID: grant 1, beat tagged 2
    do_reset();
    #1;
    check("rst_clears_err", err, 0);
    m_arlen[4 +: 4] = 4'd0;
    m_arvalid       = 3'b010;
    ARREADY         = 1'b1;
    step();
    #1;
    check("rid_arid", ARID, 1);
    m_arvalid = 3'b000;
    step();
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    RID     = 4'd2;
    RLAST   = 1'b1;
    #1;
    check("rid_steer", m_rvalid, 3'b010);
    step();
    RVALID = 1'b0;
    RLAST  = 1'b0;
    #1;
    check("rid_err", err, 1);

    // RVALID while IDLE is refused and flagged
    do_reset();
    RVALID = 1'b1;
    RID    = 4'd0;
    #1;
    check("idle_rready", RREADY, 0);
    check("idle_rvalid", m_rvalid, 0);
    step();
    RVALID = 1'b0;
    #1;
    check("idle_beat_err", err, 1);

    // reset mid-DATA returns to IDLE and rr_ptr=0
    m_arlen   = '0;
    m_arvalid = 3'b001;
    do_burst(0, 0);
    m_arlen[4 +: 4] = 4'd2;
    m_arvalid       = 3'b010;
    ARREADY         = 1'b1;
    step();
    m_arvalid = 3'b000;
    step();
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    RID     = 4'd1;
    RLAST   = 1'b0;
    #1;
    check("mid_steer", m_rvalid, 3'b010);
    step();
    rst = 1'b1;
    step();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rvalid", m_rvalid, 0);
    check("mid_rst_rready", RREADY, 0);
    check("mid_rst_arvalid", ARVALID, 0);
    check("mid_rst_err", err, 0);
    rst       = 1'b0;
    RVALID    = 1'b0;
    m_arlen   = '0;
    m_arvalid = 3'b111;
    do_burst(0, 0);
    m_arvalid = 3'b000;

`ifdef ARB_WATCHDOG_EN
    // watchdog: ARREADY never comes; abort after 16 ADDR cycles
    do_reset();
    m_arvalid = 3'b001;
    for (int c = 1; c <= 16; c++) begin
      step();
      m_arvalid = 3'b000;
      #1;
      check("wd_busy", busy, 1);
    end
    step();
    #1;
    check("wd_abort_busy", busy, 0);
    check("wd_err", err, 1);
    m_arvalid = 3'b011;
    do_burst(1, 0);
    m_arvalid = 3'b000;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
